// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring integer divider (DIV / DIVU).
//
// Holds the pipeline through stall_div while a divide is in flight and
// asserts ready for as long as the result is valid. The result is packed as
// {remainder, quotient} so that HI gets the remainder and LO the quotient.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      DIV/DIVU present in EXE (held high while stalled)
//   signed_div 1 = two's-complement divide, 0 = unsigned
//   opa, opb   dividend / divisor, sampled only on the IDLE->BUSY transition
//   flush      annul the current operation; overrides start and hold
//   hold       pipeline frozen elsewhere; keeps a finished result in DONE
//   stall_div  stall request to the hazard unit
//   ready      result valid this cycle
//   result     {remainder, quotient}
//
// Build option DIV_BYZERO_FAST_EN: when defined, a zero divisor skips the
// iteration and completes one cycle after start with {opa, all-ones}.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; stall_div follows start in the request cycle
// BUSY  | one shift-subtract step per cycle, DATA_W steps in total
// DONE  | result registered, ready high; waits here while hold is high

module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    input  logic                flush,
    input  logic                hold,
    output logic                stall_div,
    output logic                ready,
    output logic [2*DATA_W-1:0] result
);

    localparam int ACC_W = 2*DATA_W + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} divStateT;

    divStateT          state;
    divStateT          nextState;
    logic [ACC_W-1:0]  accReg;      // {remainder (DATA_W+1), quotient (DATA_W)}
    logic [DATA_W-1:0] divisorReg;
    logic              signQ;
    logic              signR;
    logic [CNT_W-1:0]  iterCnt;

    logic [DATA_W-1:0] absA;
    logic [DATA_W-1:0] absB;
    logic [ACC_W-1:0]  shifted;
    logic [ACC_W-1:0]  divShift;
    logic              canSub;
    logic [ACC_W-1:0]  stepAcc;
    logic              lastStep;
    logic [DATA_W-1:0] quotFinal;
    logic [DATA_W-1:0] remFinal;
    logic              startReq;

    assign absA     = (signed_div && opa[DATA_W-1]) ? -opa : opa;
    assign absB     = (signed_div && opb[DATA_W-1]) ? -opb : opb;
    assign startReq = start & ~flush;

    // The divisor is aligned with the remainder field so the whole step is a
    // single full-width compare/subtract; bit 0 of the shifted value is the
    // freshly vacated quotient bit.
    assign shifted   = accReg << 1;
    assign divShift  = {1'b0, divisorReg, {DATA_W{1'b0}}};
    assign canSub    = (shifted >= divShift);
    assign stepAcc   = canSub ? ((shifted - divShift) | ACC_W'(1)) : shifted;
    assign lastStep  = (iterCnt == CNT_W'(DATA_W - 1));

    // Sign fix-up is taken from the value produced by the final step so the
    // corrected result can be registered on the BUSY->DONE edge.
    assign quotFinal = signQ ? -stepAcc[DATA_W-1:0]        : stepAcc[DATA_W-1:0];
    assign remFinal  = signR ? -stepAcc[2*DATA_W-1:DATA_W] : stepAcc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        stall_div = 1'b0;
        ready     = 1'b0;
        if (flush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    stall_div = start;
                    if (start) begin
`ifdef DIV_BYZERO_FAST_EN
                        nextState = (opb == '0) ? DONE : BUSY;
`else
                        nextState = BUSY;
`endif
                    end
                end
                BUSY: begin
                    stall_div = 1'b1;
                    if (lastStep) begin
                        nextState = DONE;
                    end
                end
                DONE: begin
                    ready = 1'b1;
                    if (!hold) begin
                        nextState = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accReg     <= '0;
            divisorReg <= '0;
            signQ      <= 1'b0;
            signR      <= 1'b0;
            iterCnt    <= '0;
            result     <= '0;
        end else if (state == IDLE && startReq) begin
            accReg     <= {{(DATA_W+1){1'b0}}, absA};
            divisorReg <= absB;
            signQ      <= signed_div & (opa[DATA_W-1] ^ opb[DATA_W-1]);
            signR      <= signed_div & opa[DATA_W-1];
            iterCnt    <= '0;
`ifdef DIV_BYZERO_FAST_EN
            if (opb == '0) begin
                result <= {opa, {DATA_W{1'b1}}};
            end
`endif
        end else if (state == BUSY && !flush) begin
            accReg  <= stepAcc;
            iterCnt <= iterCnt + CNT_W'(1);
            if (lastStep) begin
                result <= {remFinal, quotFinal};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        hold;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    int total     = 0;
    int passCount = 0;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opa(opa), .opb(opb), .flush(flush), .hold(hold),
        .stall_div(stall_div), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference: divide magnitudes with plain arithmetic, then apply signs.
    function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, q, r;
        bit negA, negB;
        logic [31:0] qo, ro;
`ifdef DIV_BYZERO_FAST_EN
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
`endif
        negA = sgn && a[31];
        negB = sgn && b[31];
        ua = negA ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
        ub = negB ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
        if (ub == 0) begin
            q = 64'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        qo = q[31:0];
        ro = r[31:0];
        if (negA ^ negB) qo = -qo;
        if (negA) ro = -ro;
        return {ro, qo};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passCount = passCount + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issues one operation, scrambles the operand inputs while it runs and
    // checks latency, stall coverage, the ready-cycle stall and the result.
    // Returns at the negative edge of the ready cycle.
    task automatic runOp(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expRes, input bit keepStart);
        int lat;
        int expLat;
        bit stallOk;
        expLat = 33;
`ifdef DIV_BYZERO_FAST_EN
        if (b == 32'd0) expLat = 1;
`endif
        @(posedge clk); #1;
        start = 1'b1; signed_div = sgn; opa = a; opb = b;
        lat = -1;
        stallOk = 1'b1;
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = n;
                break;
            end
            if (stall_div !== 1'b1) stallOk = 1'b0;
            @(posedge clk); #1;
            opa = $urandom;
            opb = $urandom;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(expLat));
        chk({tag, ".stallBusy"}, 64'(stallOk), 64'd1);
        chk({tag, ".stallDone"}, 64'(stall_div), 64'd0);
        chk({tag, ".result"}, result, expRes);
        if (!keepStart) start = 1'b0;
    endtask

    initial begin
        bit          readySeen;
        bit          stableOk;
        bit          sgn;
        logic [31:0] a, b;
        logic [63:0] held;
        int          mode;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
        flush = 1'b0; hold = 1'b0;
        #12;
        chk("reset.stall", 64'(stall_div), 64'd0);
        chk("reset.ready", 64'(ready), 64'd0);
        chk("reset.result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        runOp("divu100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        runOp("divNeg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        runOp("div7_neg2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0);
        runOp("divOverflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);
        held = {32'h0, 32'h80000000};

        // Flush in cycle 10 of a running divide.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd1234567; opb = 32'd89;
        readySeen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ready === 1'b1) readySeen = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("flush.stall", 64'(stall_div), 64'd0);
        chk("flush.ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush.idleStall", 64'(stall_div), 64'd0);
        chk("flush.noReady", 64'(readySeen | ready), 64'd0);
        chk("flush.resultKept", result, held);
        runOp("afterFlush", 1'b0, 32'd1000003, 32'd17, refDiv(1'b0, 32'd1000003, 32'd17), 1'b0);

        // Hold across DONE with start left high.
        runOp("holdOp", 1'b1, 32'hFFFF0000, 32'd3, refDiv(1'b1, 32'hFFFF0000, 32'd3), 1'b1);
        held = result;
        hold = 1'b1;
        stableOk = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 5) hold = 1'b0;
            @(negedge clk);
            if (ready !== 1'b1 || result !== held) stableOk = 1'b0;
        end
        chk("hold.stable", 64'(stableOk), 64'd1);
        chk("hold.resultHeld", result, refDiv(1'b1, 32'hFFFF0000, 32'd3));
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold.releaseReady", 64'(ready), 64'd0);
        chk("hold.newRequest", 64'(stall_div), 64'd1);
        start = 1'b0;

        runOp("divu5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b0);
        runOp("divNeg5_0", 1'b1, 32'hFFFFFFFB, 32'd0, refDiv(1'b1, 32'hFFFFFFFB, 32'd0), 1'b0);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd99999; opb = 32'd7;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        chk("asyncRst.stall", 64'(stall_div), 64'd0);
        chk("asyncRst.ready", 64'(ready), 64'd0);
        chk("asyncRst.result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) b = 32'd0;
            if (mode == 1) begin
                b = $urandom_range(1, 15);
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            if (mode == 2) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            runOp($sformatf("rand%0d", i), sgn, a, b, refDiv(sgn, a, b), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, total);
        $finish;
    end

endmodule
